// File: rtl/peak_hasher.sv
// peak_hasher: pairs every peak of a new frame with the peaks of the last DEPTH frames
// and streams {anchor_freq, target_freq, dt} hashes. Optional macro: PEAK_HASHER_AMPL_THRESHOLD_EN.
module peak_hasher #(
  parameter int PEAKS      = 6,
  parameter int FREQ_WIDTH = 8,
  parameter int AMPL_WIDTH = 16,
  parameter int DEPTH      = 3,
  parameter int DT_WIDTH   = 4,
  parameter int TIME_WIDTH = 16,
  parameter int MIN_AMPL   = 1
) (
  input  logic                             CLOCK_50,
  input  logic                             reset,
  input  logic                             valid_in,
  input  logic [PEAKS*FREQ_WIDTH-1:0]      freqs_in,
  input  logic [PEAKS*AMPL_WIDTH-1:0]      amplitudes_in,
  input  logic                             hash_ready,
  output logic                             hash_valid,
  output logic [2*FREQ_WIDTH+DT_WIDTH-1:0] hash_out,
  output logic [TIME_WIDTH-1:0]            anchor_time_out,
  output logic                             busy,
  output logic [7:0]                       drop_count
);

  // state  | meaning
  // IDLE   | waiting for a frame; busy drops here one cycle after COMMIT
  // SCAN   | walking d, a, t over buffered anchors vs staged targets
  // COMMIT | staged frame enters the history, frame_time advances

  localparam int PW = (PEAKS > 1) ? $clog2(PEAKS) : 1;
  localparam int HW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]       LAST_PEAK = PW'(PEAKS - 1);
  localparam logic [DT_WIDTH-1:0] FULL_FILL = DT_WIDTH'(DEPTH);

  if (DEPTH < 1 || DT_WIDTH < $clog2(DEPTH + 1) || MIN_AMPL < 0 ||
      longint'(MIN_AMPL) >= (longint'(1) << AMPL_WIDTH)) begin : g_bad_cfg
    $error("peak_hasher: inconsistent parameters");
  end

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t                state;
  logic [FREQ_WIDTH-1:0] stage_freq [PEAKS];
  logic [AMPL_WIDTH-1:0] stage_ampl [PEAKS];
  logic [FREQ_WIDTH-1:0] hist_freq  [DEPTH][PEAKS];
  logic [AMPL_WIDTH-1:0] hist_ampl  [DEPTH][PEAKS];
  logic [DT_WIDTH-1:0]   fill;
  logic [TIME_WIDTH-1:0] frame_time;
  logic [HW-1:0]         d_idx;
  logic [PW-1:0]         a_idx;
  logic [PW-1:0]         t_idx;

  logic [DT_WIDTH-1:0]   d_val;
  logic [FREQ_WIDTH-1:0] anchor_freq;
  logic [FREQ_WIDTH-1:0] target_freq;
  logic [AMPL_WIDTH-1:0] anchor_ampl;
  logic [AMPL_WIDTH-1:0] target_ampl;
  logic                  eligible;
  logic                  advance;
  logic                  last_combo;

  // d_idx holds d-1 so it indexes the history directly; hist[0] is the newest frame.
  assign d_val       = DT_WIDTH'(d_idx) + DT_WIDTH'(1);
  assign anchor_freq = hist_freq[d_idx][a_idx];
  assign anchor_ampl = hist_ampl[d_idx][a_idx];
  assign target_freq = stage_freq[t_idx];
  assign target_ampl = stage_ampl[t_idx];
  assign advance     = !hash_valid || hash_ready;
  assign last_combo  = (d_val == fill) && (a_idx == LAST_PEAK) && (t_idx == LAST_PEAK);

`ifdef PEAK_HASHER_AMPL_THRESHOLD_EN
  localparam logic [AMPL_WIDTH-1:0] AMPL_FLOOR = AMPL_WIDTH'(MIN_AMPL);
  assign eligible = (anchor_ampl >= AMPL_FLOOR) && (target_ampl >= AMPL_FLOOR);
`else
  assign eligible = (anchor_ampl != '0) && (target_ampl != '0);
`endif

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      hash_valid      <= 1'b0;
      hash_out        <= '0;
      anchor_time_out <= '0;
      busy            <= 1'b0;
      drop_count      <= '0;
      fill            <= '0;
      frame_time      <= '0;
      d_idx           <= '0;
      a_idx           <= '0;
      t_idx           <= '0;
      for (int p = 0; p < PEAKS; p++) begin
        stage_freq[p] <= '0;
        stage_ampl[p] <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          hist_freq[k][p] <= '0;
          hist_ampl[k][p] <= '0;
        end
      end
    end else begin
      if (hash_valid && hash_ready) begin
        hash_valid <= 1'b0;
      end

      if (valid_in && state != IDLE && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end

      case (state)
        IDLE: begin
          busy <= valid_in;
          if (valid_in) begin
            for (int p = 0; p < PEAKS; p++) begin
              stage_freq[p] <= freqs_in[p*FREQ_WIDTH +: FREQ_WIDTH];
              stage_ampl[p] <= amplitudes_in[p*AMPL_WIDTH +: AMPL_WIDTH];
            end
            d_idx <= '0;
            a_idx <= '0;
            t_idx <= '0;
            state <= (fill == '0) ? COMMIT : SCAN;
          end
        end

        SCAN: begin
          if (advance) begin
            if (eligible) begin
              hash_out        <= {anchor_freq, target_freq, d_val};
              anchor_time_out <= frame_time - TIME_WIDTH'(d_val);
              hash_valid      <= 1'b1;
            end
            if (last_combo) begin
              state <= COMMIT;
            end else if (t_idx == LAST_PEAK) begin
              t_idx <= '0;
              if (a_idx == LAST_PEAK) begin
                a_idx <= '0;
                d_idx <= d_idx + 1'b1;
              end else begin
                a_idx <= a_idx + 1'b1;
              end
            end else begin
              t_idx <= t_idx + 1'b1;
            end
          end
        end

        COMMIT: begin
          for (int p = 0; p < PEAKS; p++) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
              hist_freq[k][p] <= hist_freq[k-1][p];
              hist_ampl[k][p] <= hist_ampl[k-1][p];
            end
            hist_freq[0][p] <= stage_freq[p];
            hist_ampl[0][p] <= stage_ampl[p];
          end
          if (fill != FULL_FILL) begin
            fill <= fill + DT_WIDTH'(1);
          end
          frame_time <= frame_time + TIME_WIDTH'(1);
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
